// File: rtl/jtag_scan_master_if.sv
// Host-side request/response bundle for jtag_scan_master.
// JTAG_SCAN_RTI_WAIT_EN adds the rti_cycles request field.
interface jtag_scan_master_if #(
  parameter int unsigned IR_WIDTH     = 4,
  parameter int unsigned DR_MAX_WIDTH = 64
);
  logic                    start;
  logic                    is_ir;
  logic [6:0]              length;
  logic [IR_WIDTH-1:0]     ir_value;
  logic [DR_MAX_WIDTH-1:0] dr_in;
  logic [DR_MAX_WIDTH-1:0] dr_out;
  logic                    busy;
  logic                    done;
`ifdef JTAG_SCAN_RTI_WAIT_EN
  logic [7:0]              rti_cycles;

  modport master (output start, is_ir, length, ir_value, dr_in, rti_cycles,
                  input  dr_out, busy, done);
  modport slave  (input  start, is_ir, length, ir_value, dr_in, rti_cycles,
                  output dr_out, busy, done);
`else
  modport master (output start, is_ir, length, ir_value, dr_in,
                  input  dr_out, busy, done);
  modport slave  (input  start, is_ir, length, ir_value, dr_in,
                  output dr_out, busy, done);
`endif
endinterface

// File: rtl/jtag_scan_master.sv
// JTAG TAP scan master: resets the TAP to Run-Test/Idle, then runs LSB-first IR/DR scans.
// Optional macro JTAG_SCAN_RTI_WAIT_EN adds a per-request Run-Test/Idle dwell (rti_cycles).
module jtag_scan_master #(
  parameter int unsigned IR_WIDTH     = 4,
  parameter int unsigned DR_MAX_WIDTH = 64,
  parameter int unsigned CLK_DIV      = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  jtag_scan_master_if.slave bus,
  output logic              tck,
  output logic              tms,
  output logic              tdi,
  input  logic              tdo
);
  localparam int unsigned PH_W         = $clog2(2 * CLK_DIV);
  localparam int unsigned LEN_W        = 7;
  localparam int unsigned BIT_W        = $clog2(DR_MAX_WIDTH);
  localparam int unsigned PER_W        = 10;
  localparam int unsigned INIT_PERIODS = 6;

  typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_SCAN} state_t;

  state_t                  state;
  logic [PH_W-1:0]         ph;
  logic [PER_W-1:0]        per;
  logic [PER_W-1:0]        total;
  logic                    ir_scan;
  logic [LEN_W-1:0]        n_bits;
  logic [DR_MAX_WIDTH-1:0] sh;
  logic [DR_MAX_WIDTH-1:0] cap;

  logic                    ph_last_c;
  logic                    ph_rise_c;
  logic [PH_W-1:0]         ph_next_c;
  logic                    tck_next_c;
  logic [PER_W-1:0]        per_next_c;
  logic [PER_W-1:0]        pre_c;
  logic [PER_W-1:0]        shift_end_c;
  logic                    in_shift_c;
  logic                    next_shift_c;
  logic [BIT_W-1:0]        bit_idx_c;
  logic                    tms_next_c;
  logic [LEN_W-1:0]        len_c;
  logic [LEN_W-1:0]        n_c;
  logic [PER_W-1:0]        rti_c;
  logic [PER_W-1:0]        total_c;

  // Divider phase, per-period TMS/TDI selection and request decode.
  always_comb begin
    ph_last_c    = (ph == PH_W'(2 * CLK_DIV - 1));
    ph_rise_c    = (ph == PH_W'(CLK_DIV - 1));
    ph_next_c    = ph_last_c ? '0 : ph + PH_W'(1);
    tck_next_c   = (ph_next_c >= PH_W'(CLK_DIV));
    per_next_c   = per + PER_W'(1);
    pre_c        = ir_scan ? PER_W'(4) : PER_W'(3);
    shift_end_c  = pre_c + PER_W'(n_bits);
    in_shift_c   = (per >= pre_c) && (per < shift_end_c);
    next_shift_c = (per_next_c >= pre_c) && (per_next_c < shift_end_c);
    bit_idx_c    = BIT_W'(per - pre_c);
    tms_next_c   = 1'b0;
    if (per_next_c < pre_c)
      tms_next_c = ir_scan ? (per_next_c < PER_W'(2)) : (per_next_c == '0);
    else if (next_shift_c)
      tms_next_c = (per_next_c == shift_end_c - PER_W'(1));
    else
      tms_next_c = (per_next_c == shift_end_c);

    len_c = bus.length;
    if (bus.length == '0)
      len_c = LEN_W'(1);
    else if (bus.length > LEN_W'(DR_MAX_WIDTH))
      len_c = LEN_W'(DR_MAX_WIDTH);
    n_c = bus.is_ir ? LEN_W'(IR_WIDTH) : len_c;
`ifdef JTAG_SCAN_RTI_WAIT_EN
    rti_c = PER_W'(bus.rti_cycles);
`else
    rti_c = '0;
`endif
    total_c = (bus.is_ir ? PER_W'(6) : PER_W'(5)) + PER_W'(n_c) + rti_c;
  end

  // Sequencer: TMS/TDI update at tck fall, TDO capture at tck rise.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_INIT;
      ph         <= '0;
      per        <= '0;
      total      <= '0;
      ir_scan    <= 1'b0;
      n_bits     <= '0;
      sh         <= '0;
      cap        <= '0;
      tck        <= 1'b0;
      tms        <= 1'b1;
      tdi        <= 1'b0;
      bus.busy   <= 1'b1;
      bus.done   <= 1'b0;
      bus.dr_out <= '0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        ST_INIT: begin
          ph  <= ph_next_c;
          tck <= tck_next_c;
          if (ph_last_c) begin
            if (per == PER_W'(INIT_PERIODS - 1)) begin
              state    <= ST_IDLE;
              per      <= '0;
              tms      <= 1'b0;
              bus.busy <= 1'b0;
            end else begin
              per <= per_next_c;
              tms <= (per_next_c < PER_W'(INIT_PERIODS - 1));
            end
          end
        end
        ST_IDLE: begin
          ph  <= '0;
          tck <= 1'b0;
          tms <= 1'b0;
          tdi <= 1'b0;
          if (bus.start) begin
            state    <= ST_SCAN;
            per      <= '0;
            total    <= total_c;
            ir_scan  <= bus.is_ir;
            n_bits   <= n_c;
            sh       <= bus.is_ir ? DR_MAX_WIDTH'(bus.ir_value) : bus.dr_in;
            cap      <= '0;
            tms      <= 1'b1;
            bus.busy <= 1'b1;
          end
        end
        ST_SCAN: begin
          ph  <= ph_next_c;
          tck <= tck_next_c;
          if (ph_rise_c && in_shift_c)
            cap[bit_idx_c] <= tdo;
          if (ph_last_c) begin
            if (per_next_c == total) begin
              state      <= ST_IDLE;
              per        <= '0;
              tms        <= 1'b0;
              tdi        <= 1'b0;
              bus.busy   <= 1'b0;
              bus.done   <= 1'b1;
              bus.dr_out <= cap;
            end else begin
              per <= per_next_c;
              tms <= tms_next_c;
              if (next_shift_c) begin
                tdi <= sh[0];
                sh  <= sh >> 1;
              end else begin
                tdi <= 1'b0;
              end
            end
          end
        end
        default: state <= ST_INIT;
      endcase
    end
  end
endmodule

// File: tb/tb_jtag_scan_master.sv
// Directed bench for jtag_scan_master against a behavioural 1149.1 TAP with a 64-bit DR.
// Define JTAG_SCAN_RTI_WAIT_EN to also exercise the Run-Test/Idle dwell.
module tb_jtag_scan_master;
  localparam int unsigned IRW  = 4;
  localparam int unsigned DRW  = 64;
  localparam int unsigned CDIV = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic tck, tms, tdi;
  logic tdo   = 1'b0;

  always #5 clk = ~clk;

  jtag_scan_master_if #(.IR_WIDTH(IRW), .DR_MAX_WIDTH(DRW)) bus ();

  jtag_scan_master #(.IR_WIDTH(IRW), .DR_MAX_WIDTH(DRW), .CLK_DIV(CDIV)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .tck(tck), .tms(tms), .tdi(tdi), .tdo(tdo)
  );

  typedef enum logic [3:0] {TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PA_DR, EX2_DR, UPD_DR,
                            SEL_IR, CAP_IR, SH_IR, EX1_IR, PA_IR, EX2_IR, UPD_IR} tap_t;
  tap_t        tap    = TLR;
  logic [63:0] m_dr   = 64'h0000_0000_0012_3456;
  logic [63:0] m_dsr  = '0;
  logic [3:0]  m_ir   = 4'b0001;
  logic [3:0]  m_isr  = '0;
  int          m_shifts = 0;
  logic        tms_hist [0:4095];
  logic        tdi_hist [0:4095];
  int          rise_cnt = 0;
  int          done_cnt = 0;

  // Target TAP: state moves and shifts on tck rise, update and TDO on tck fall.
  always @(posedge tck) begin
    tms_hist[rise_cnt] <= tms;
    tdi_hist[rise_cnt] <= tdi;
    rise_cnt <= rise_cnt + 1;
    case (tap)
      CAP_DR: m_dsr <= m_dr;
      SH_DR: begin m_dsr <= {tdi, m_dsr[63:1]}; m_shifts <= m_shifts + 1; end
      CAP_IR: m_isr <= 4'b0101;
      SH_IR:  m_isr <= {tdi, m_isr[3:1]};
      default: ;
    endcase
    case (tap)
      TLR:    tap <= tms ? TLR    : RTI;
      RTI:    tap <= tms ? SEL_DR : RTI;
      SEL_DR: tap <= tms ? SEL_IR : CAP_DR;
      CAP_DR: tap <= tms ? EX1_DR : SH_DR;
      SH_DR:  tap <= tms ? EX1_DR : SH_DR;
      EX1_DR: tap <= tms ? UPD_DR : PA_DR;
      PA_DR:  tap <= tms ? EX2_DR : PA_DR;
      EX2_DR: tap <= tms ? UPD_DR : SH_DR;
      UPD_DR: tap <= tms ? SEL_DR : RTI;
      SEL_IR: tap <= tms ? TLR    : CAP_IR;
      CAP_IR: tap <= tms ? EX1_IR : SH_IR;
      SH_IR:  tap <= tms ? EX1_IR : SH_IR;
      EX1_IR: tap <= tms ? UPD_IR : PA_IR;
      PA_IR:  tap <= tms ? EX2_IR : PA_IR;
      EX2_IR: tap <= tms ? UPD_IR : SH_IR;
      default: tap <= tms ? SEL_DR : RTI;
    endcase
  end

  always @(negedge tck) begin
    if (tap == UPD_DR) m_dr <= m_dsr;
    if (tap == UPD_IR) m_ir <= m_isr;
    if (tap == TLR)    m_ir <= 4'b0001;
    tdo <= (tap == SH_DR) ? m_dsr[0] : (tap == SH_IR) ? m_isr[0] : 1'b0;
  end

  always @(negedge clk) if (bus.done === 1'b1) done_cnt <= done_cnt + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic count_busy(output int cyc);
    cyc = 0;
    while (bus.busy === 1'b1 && cyc < 4000) begin
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic run_scan(input logic ir, input logic [6:0] len, input logic [3:0] irv,
                          input logic [63:0] din, input logic [7:0] rti, input int poke_at,
                          output int cyc, output logic done_seen);
    bus.start = 1'b1; bus.is_ir = ir; bus.length = len; bus.ir_value = irv; bus.dr_in = din;
`ifdef JTAG_SCAN_RTI_WAIT_EN
    bus.rti_cycles = rti;
`else
    if (rti != 8'd0) $display("note: rti ignored in this build");
`endif
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 0;
    while (bus.busy === 1'b1 && cyc < 4000) begin
      bus.start = (cyc == poke_at);
      bus.is_ir = 1'b1;
      @(negedge clk);
      cyc++;
    end
    bus.start = 1'b0;
    done_seen = bus.done;
  endtask

  task automatic get_log(input int from, input int cnt, output logic [15:0] tl, output logic [15:0] dl);
    tl = '0; dl = '0;
    for (int i = 0; i < cnt; i++) begin
      tl = {tl[14:0], tms_hist[from + i]};
      dl = {dl[14:0], tdi_hist[from + i]};
    end
  endtask

  initial begin
    int cyc, r0, s0, d0;
    logic dn;
    logic [15:0] tl, dl;

    bus.start = 1'b0; bus.is_ir = 1'b0; bus.length = '0; bus.ir_value = '0; bus.dr_in = '0;
`ifdef JTAG_SCAN_RTI_WAIT_EN
    bus.rti_cycles = '0;
`endif
    repeat (3) @(negedge clk);
    check("rst_tck", 64'(tck), 64'd0);
    check("rst_tms", 64'(tms), 64'd1);
    check("rst_tdi", 64'(tdi), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd1);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_dr_out", bus.dr_out, 64'd0);

    // INIT: 6 TCK periods, TMS 1,1,1,1,1,0, busy for 48 clks.
    r0 = rise_cnt;
    rst_n = 1'b1;
    count_busy(cyc);
    check("init_busy_clks", 64'(cyc), 64'd48);
    check("init_rises", 64'(rise_cnt - r0), 64'd6);
    get_log(r0, 6, tl, dl);
    check("init_tms", 64'(tl), 64'b111110);
    check("init_tap_rti", 64'(tap), 64'(RTI));
    repeat (2) @(negedge clk);
    check("init_no_done", 64'(done_cnt), 64'd0);
    check("idle_tck", 64'(tck), 64'd0);
    check("idle_tms", 64'(tms), 64'd0);

    // IR scan 1111: captured 0101 comes back.
    r0 = rise_cnt;
    run_scan(1'b1, 7'd0, 4'b1111, 64'd0, 8'd0, -1, cyc, dn);
    check("ir_clks", 64'(cyc), 64'd80);
    check("ir_done", 64'(dn), 64'd1);
    get_log(r0, 10, tl, dl);
    check("ir_tms", 64'(tl), 64'b1100000110);
    check("ir_tdi", 64'(dl), 64'b0000111100);
    check("ir_model", 64'(m_ir), 64'hF);
    check("ir_dr_out", bus.dr_out, 64'h5);

    // DR 32 bits.
    s0 = m_shifts;
    run_scan(1'b0, 7'd32, 4'd0, 64'h0000_0000_1357_9BDF, 8'd0, -1, cyc, dn);
    check("dr32_clks", 64'(cyc), 64'd296);
    check("dr32_done", 64'(dn), 64'd1);
    check("dr32_dr_out", bus.dr_out, 64'h0000_0000_0012_3456);
    check("dr32_shifts", 64'(m_shifts - s0), 64'd32);
    check("dr32_model", m_dr, 64'h1357_9BDF_0000_0000);

    // DR 64 bits.
    run_scan(1'b0, 7'd64, 4'd0, 64'hDEADBEEF_CAFEF00D, 8'd0, -1, cyc, dn);
    check("dr64_clks", 64'(cyc), 64'd552);
    check("dr64_dr_out", bus.dr_out, 64'h1357_9BDF_0000_0000);
    check("dr64_model", m_dr, 64'hDEADBEEF_CAFEF00D);

    // length=0 shifts exactly one bit.
    s0 = m_shifts;
    run_scan(1'b0, 7'd0, 4'd0, 64'h1, 8'd0, -1, cyc, dn);
    check("len0_clks", 64'(cyc), 64'd48);
    check("len0_shifts", 64'(m_shifts - s0), 64'd1);
    check("len0_dr_out", bus.dr_out, 64'h1);
    check("len0_model", m_dr, 64'hEF56DF77_E57F7806);

    // length=100 clamps to 64.
    s0 = m_shifts;
    run_scan(1'b0, 7'd100, 4'd0, 64'd0, 8'd0, -1, cyc, dn);
    check("len100_clks", 64'(cyc), 64'd552);
    check("len100_shifts", 64'(m_shifts - s0), 64'd64);
    check("len100_dr_out", bus.dr_out, 64'hEF56DF77_E57F7806);
    check("len100_model", m_dr, 64'd0);

    // start while busy is ignored.
    repeat (2) @(negedge clk);
    d0 = done_cnt;
    run_scan(1'b0, 7'd8, 4'd0, 64'hFF, 8'd0, 20, cyc, dn);
    check("busy_start_clks", 64'(cyc), 64'd104);
    check("busy_start_model", m_dr, 64'hFF00_0000_0000_0000);
    repeat (20) @(negedge clk);
    check("busy_start_idle", 64'(bus.busy), 64'd0);
    check("busy_start_one_done", 64'(done_cnt - d0), 64'd1);

    // Reset for one clk in the middle of a DR shift.
    d0 = done_cnt;
    bus.start = 1'b1; bus.is_ir = 1'b0; bus.length = 7'd64; bus.dr_in = 64'h0123_4567_89AB_CDEF;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (13 * 8 + 3) @(negedge clk);
    check("mid_in_shift", 64'(tap), 64'(SH_DR));
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_tck", 64'(tck), 64'd0);
    check("mid_rst_tms", 64'(tms), 64'd1);
    check("mid_rst_done", 64'(bus.done), 64'd0);
    check("mid_rst_dr_out", bus.dr_out, 64'd0);
    rst_n = 1'b1;
    r0 = rise_cnt;
    count_busy(cyc);
    check("mid_init_clks", 64'(cyc), 64'd48);
    get_log(r0, 6, tl, dl);
    check("mid_init_tms", 64'(tl), 64'b111110);
    check("mid_tap_rti", 64'(tap), 64'(RTI));
    repeat (2) @(negedge clk);
    check("mid_no_done", 64'(done_cnt - d0), 64'd0);

    run_scan(1'b1, 7'd0, 4'b0110, 64'd0, 8'd0, -1, cyc, dn);
    check("post_ir_clks", 64'(cyc), 64'd80);
    check("post_ir_model", 64'(m_ir), 64'h6);
    check("post_ir_dr_out", bus.dr_out, 64'h5);

`ifdef JTAG_SCAN_RTI_WAIT_EN
    r0 = rise_cnt;
    run_scan(1'b0, 7'd1, 4'd0, 64'd0, 8'd3, -1, cyc, dn);
    check("rti_clks", 64'(cyc), 64'd72);
    get_log(r0, 9, tl, dl);
    check("rti_tms", 64'(tl), 64'b100110000);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
